// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
// Holds FSM state encodings, the default error read data and the requester ids.
package mem_port_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'b00;
    localparam state_t ST_D_WAIT = 2'b01;
    localparam state_t ST_I_WAIT = 2'b10;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_wdog.sv
// Watchdog for an outstanding memory transaction: flags the cycle in which
// the TIMEOUT-th wait cycle ends without an ack. TIMEOUT=0 removes it.
module mem_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_wdog;
            assign unused_wdog = ^{clk, reset, run, clear};
            assign expired     = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT + 1);
            logic [W-1:0] cnt;
            logic [W-1:0] nxt;

            // cnt holds completed wait cycles; nxt includes the one ending now
            assign nxt     = cnt + W'(1);
            assign expired = run && (nxt == W'(TIMEOUT));

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt <= '0;
                else if (clear || !run)
                    cnt <= '0;
                else
                    cnt <= nxt;
            end
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, variable-latency memory between the IF fetch port
// and the MEM load/store port, with data priority bounded by a fetch-starvation limit.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          D_STREAK_MAX = 4,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int SW = $clog2(D_STREAK_MAX + 1);

    state_t        state;
    logic [SW-1:0] streak;
    logic          d_any, d_win, i_win, in_wait, done, expired, owner;
    logic [31:0]   rd_val;

    assign d_any    = d_re | d_we;
    assign d_win    = (state == ST_IDLE) && d_any && !(if_req && streak == SW'(D_STREAK_MAX));
    assign i_win    = (state == ST_IDLE) && !d_win && if_req;
    assign in_wait  = (state == ST_D_WAIT) || (state == ST_I_WAIT);
    assign done     = in_wait && (mem_ack || expired);
    assign owner    = (state == ST_D_WAIT) ? PORT_D : PORT_I;
    // ack wins over a coincident timeout
    assign rd_val   = mem_ack ? mem_rdata : ERR_DATA;

    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_any & ~d_ready;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .run     (in_wait),
        .clear   (d_win | i_win),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_win) begin
                        state     <= ST_D_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        err       <= d_re & d_we;
                    end else if (i_win) begin
                        state    <= ST_I_WAIT;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                ST_D_WAIT, ST_I_WAIT: begin
                    if (done) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        err     <= ~mem_ack;
                        if (owner == PORT_D) begin
                            d_ready <= 1'b1;
                            if (!mem_we)
                                d_rdata <= rd_val;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= rd_val;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // streak only moves in IDLE; a fetch grant or an absent fetch clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            streak <= '0;
        else if (state == ST_IDLE) begin
            if (!if_req || i_win)
                streak <= '0;
            else if (d_win && streak != SW'(D_STREAK_MAX))
                streak <= streak + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small ack-delay memory model plus
// hand-computed expectations for fetch, collision, store, starvation, timeout and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_re, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        if_ready, if_stall, d_ready, d_stall, mem_req, mem_we, err;

    // memory model controls, written only by the main process
    int          ack_delay = 1;
    logic        mem_en = 1'b1;
    logic        late_ack = 1'b0;
    logic [31:0] rd_val = '0;
    int          wcnt = 0;
    logic [31:0] gq[$];

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.D_STREAK_MAX(4), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    // memory: acks ack_delay cycles after mem_req rises, logs each grant address
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack <= 1'b0;
            wcnt    <= 0;
        end else if (mem_req) begin
            if (wcnt == 0) gq.push_back(mem_addr);
            wcnt <= wcnt + 1;
            if (mem_en && wcnt + 1 == ack_delay) begin
                mem_ack   <= 1'b1;
                mem_rdata <= rd_val;
            end
        end else begin
            wcnt <= 0;
            if (late_ack) begin
                mem_ack   <= 1'b1;
                mem_rdata <= 32'h12345678;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [31:0] exp_order [6];
        logic [31:0] got;

        reset = 1'b1; if_req = 0; d_re = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        #3;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ready",   {30'd0, if_ready, d_ready}, 32'd0);
        chk("rst_err",     {31'd0, err}, 32'd0);
        chk("rst_addr",    mem_addr, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // fetch only
        if_req = 1; if_addr = 32'h10; rd_val = 32'h00500093; ack_delay = 1;
        #1 chk("f_stall_c0", {31'd0, if_stall}, 32'd1);
        step();
        chk("f_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("f_stall_c1", {31'd0, if_stall}, 32'd1);
        chk("f_rdy_c1",   {31'd0, if_ready}, 32'd0);
        step();
        chk("f_rdy_c2",   {31'd0, if_ready}, 32'd1);
        chk("f_rdata",    if_rdata, 32'h00500093);
        chk("f_stall_c2", {31'd0, if_stall}, 32'd0);
        if_req = 0;
        step();
        chk("f_rdy_pulse", {31'd0, if_ready}, 32'd0);

        // collision: data first, fetch after the bubble
        d_re = 1; d_addr = 32'h100; if_req = 1; if_addr = 32'h14; rd_val = 32'h11112222;
        step();
        chk("c_addr_d", mem_addr, 32'h100);
        chk("c_we_d",   {31'd0, mem_we}, 32'd0);
        step();
        chk("c_d_ready", {30'd0, if_ready, d_ready}, 32'd1);
        chk("c_d_rdata", d_rdata, 32'h11112222);
        chk("c_bubble",  {31'd0, mem_req}, 32'd0);
        d_re = 0; rd_val = 32'h33334444;
        step();
        chk("c_addr_i", mem_addr, 32'h14);
        chk("c_req_i",  {31'd0, mem_req}, 32'd1);
        step();
        chk("c_i_ready", {30'd0, if_ready, d_ready}, 32'd2);
        chk("c_i_rdata", if_rdata, 32'h33334444);
        if_req = 0;
        step();

        // store with 3-cycle ack
        d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D; ack_delay = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s_req",   {31'd0, mem_req}, 32'd1);
            chk("s_we",    {31'd0, mem_we}, 32'd1);
            chk("s_wdata", mem_wdata, 32'hCAFEF00D);
            chk("s_rdy0",  {31'd0, d_ready}, 32'd0);
        end
        step();
        chk("s_ready", {31'd0, d_ready}, 32'd1);
        chk("s_rdata", d_rdata, 32'h11112222);
        d_we = 0; ack_delay = 1;
        step();

        // starvation: D,D,D,D,I,D
        base = gq.size();
        exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h40, 32'h300};
        d_re = 1; d_addr = 32'h300; if_req = 1; if_addr = 32'h40;
        repeat (11) step();
        d_re = 0; if_req = 0;
        repeat (4) step();
        chk("st_idle",  {31'd0, mem_req}, 32'd0);
        chk("st_count", gq.size() - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            got = (gq.size() > base + i) ? gq[base + i] : 32'hFFFFFFFF;
            chk($sformatf("st_grant%0d", i), got, exp_order[i]);
        end

        // timeout on a load, then a late ack
        mem_en = 0; d_re = 1; d_addr = 32'h400;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t_req%0d", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("t_rdy%0d", i), {31'd0, d_ready}, 32'd0);
        end
        step();
        chk("t_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t_ready",    {31'd0, d_ready}, 32'd1);
        chk("t_err",      {31'd0, err}, 32'd1);
        chk("t_rdata",    d_rdata, 32'hDEADBEEF);
        d_re = 0; late_ack = 1;
        step();
        late_ack = 0;
        chk("t_late_rdy",   {31'd0, d_ready}, 32'd0);
        chk("t_late_err",   {31'd0, err}, 32'd0);
        chk("t_late_rdata", d_rdata, 32'hDEADBEEF);
        mem_en = 1;
        step();

        // d_re & d_we: write, err with the grant
        d_re = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'h5A5A5A5A;
        step();
        chk("rw_err",  {31'd0, err}, 32'd1);
        chk("rw_we",   {31'd0, mem_we}, 32'd1);
        step();
        chk("rw_err_clr", {31'd0, err}, 32'd0);
        chk("rw_ready",   {31'd0, d_ready}, 32'd1);
        chk("rw_rdata",   d_rdata, 32'hDEADBEEF);
        d_re = 0; d_we = 0;
        step();

        // async reset mid D_WAIT
        mem_en = 0; d_re = 1; d_addr = 32'h600;
        step();
        chk("r_req_on", {31'd0, mem_req}, 32'd1);
        #2 reset = 1;
        #1;
        chk("r_req_off",  {31'd0, mem_req}, 32'd0);
        chk("r_if_rdata", if_rdata, 32'd0);
        #2 reset = 0; d_re = 0; mem_en = 1;
        step();
        if_req = 1; if_addr = 32'h80; rd_val = 32'h0BADF00D; ack_delay = 2;
        step();
        chk("r_f_addr", mem_addr, 32'h80);
        chk("r_f_req",  {31'd0, mem_req}, 32'd1);
        step();
        chk("r_f_rdy0", {31'd0, if_ready}, 32'd0);
        step();
        chk("r_f_rdy1",  {31'd0, if_ready}, 32'd1);
        chk("r_f_rdata", if_rdata, 32'h0BADF00D);
        if_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipelined CPU's instruction-fetch port (IF stage) and data port (MEM stage: load/store).
- Sequences each access as a req/ack transaction on the memory side.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Drives stall signals that freeze the pipeline stage while its access is outstanding.

Parameters:
- D_STREAK_MAX, 4, max consecutive data grants while a fetch is pending before fetch is forced a grant (1..15).
- TIMEOUT, 255, cycles to wait for mem_ack before aborting; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out read.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held stable until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction; valid when if_ready
- if_ready  out  1  one-cycle completion pulse, fetch
- if_stall  out  1  if_req & ~if_ready (combinational)
- d_re  in  1  load request
- d_we  in  1  store request
- d_addr  in  32  load/store address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid when d_ready
- d_ready  out  1  one-cycle completion pulse, data
- d_stall  out  1  (d_re|d_we) & ~d_ready (combinational)
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid with mem_ack
- mem_ack  in  1  single-cycle completion from memory
- err  out  1  one-cycle pulse on timeout or d_re&d_we

Behaviour:
- States: IDLE, D_WAIT, I_WAIT.
- Reset (async): state IDLE; mem_req, mem_we, if_ready, d_ready, err = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; streak and watchdog counters = 0.
- Arbitration in IDLE at each edge:
  - Data is requested (d_re|d_we) and NOT (if_req and streak==D_STREAK_MAX): grant data. Latch d_addr, d_wdata, mem_we=d_we. mem_req=1. Go to D_WAIT.
  - Otherwise, if_req: grant fetch. Latch if_addr, mem_we=0. mem_req=1. Go to I_WAIT.
  - Otherwise stay in IDLE.
- Streak counter:
  - +1 on each data grant while if_req=1.
  - Cleared on a fetch grant, or whenever if_req=0 in IDLE.
  - Saturates at D_STREAK_MAX.
- WAIT states:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant until mem_ack is sampled high.
  - On ack: mem_req=0. Read: rdata register <= mem_rdata. Pulse the corresponding ready for exactly one cycle. Return to IDLE.
  - Write: d_rdata keeps its prior value.
- Latency:
  - Request seen at edge 0.
  - mem_req high after edge 0.
  - Earliest ack sampled at edge 1.
  - Ready high after edge 1.
  - Next grant no earlier than edge 2, giving one IDLE bubble between transactions.
- Back-to-back: a requester holding its request after ready is re-arbitrated in IDLE like a new request.
- Simultaneous data and fetch requests: data wins unless the streak limit is hit.
- Request withdrawn mid-transaction: the transaction completes and ready still pulses; the requester ignores it.
- d_re & d_we both high: treated as a write; err pulses with the grant.
- Watchdog (TIMEOUT>0):
  - Counts cycles in a WAIT state.
  - At count==TIMEOUT without ack: mem_req=0, rdata register <= ERR_DATA on reads, ready pulses, err pulses, return to IDLE.
  - A late ack arriving in IDLE is ignored.
- Reset mid-transaction: immediate abort to IDLE and mem_req drops; the memory must tolerate an abandoned request.
- Ready pulses never overlap: at most one of if_ready/d_ready is high in any cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE=2'b00, D_WAIT=2'b01, I_WAIT=2'b10)
  - ERR_DATA default
  - port-id constants (PORT_I, PORT_D)
- One sub-module: mem_wdog.
  - Function: TIMEOUT counter.
  - Inputs: clk, reset, run, clear.
  - Output: expired.
  - Width: clog2(TIMEOUT+1).
  - Tied off when TIMEOUT=0.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010; memory acks 1 cycle after mem_req with 0x0050_0093 → if_rdata=0x0050_0093, if_ready one pulse at cycle 2, if_stall high cycles 0–1.
- Collision: d_re=1 at d_addr=0x100 and if_req=1 at 0x14, same cycle → data granted first (mem_addr=0x100, mem_we=0); fetch granted after the d_ready pulse plus the IDLE bubble.
- Store: d_we=1, d_addr=0x200, d_wdata=0xCAFE_F00D, ack after 3 cycles → mem_we=1 and mem_wdata stable for all 3 cycles; d_ready pulse; d_rdata unchanged.
- Starvation: d_re held continuously with if_req=1, D_STREAK_MAX=4 → grant order D,D,D,D,I,D…; streak clears after the fetch grant.
- Timeout: TIMEOUT=8, no ack on a load → mem_req drops after 8 WAIT cycles; d_rdata=0xDEADBEEF; d_ready and err pulse together; a late ack is ignored.
- Reset mid-D_WAIT: assert reset asynchronously → mem_req=0 with no clock edge; state IDLE; a fresh fetch after release completes normally.
